// File: rtl/mp1_control.sv
`default_nettype none
// ============================================================================
//  Module      : mp1_control
//  Description : Multicycle control FSM for the RV32I datapath. Walks each
//                instruction through fetch, decode and one execute path,
//                driving datapath load enables and mux selects, and
//                handshaking with the unified memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
module mp1_control #(
    parameter bit ILLEGAL_SKIP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       br_en,
    input  logic [1:0] mar_lsb,
    input  logic       mem_resp,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_regfile,
    output logic       load_mar,
    output logic       load_mdr,
    output logic       load_data_out,
    output logic [1:0] pcmux_sel,
    output logic       alumux1_sel,
    output logic [2:0] alumux2_sel,
    output logic [3:0] regfilemux_sel,
    output logic       marmux_sel,
    output logic       cmpmux_sel,
    output logic [2:0] cmpop,
    output logic [2:0] aluop,
    output logic       mem_read,
    output logic       mem_write,
    output logic [3:0] mem_byte_enable,
    output logic       illegal,
    output logic       halted
);

    typedef enum logic [3:0] {
        S_FETCH1 = 4'd0,  S_FETCH2 = 4'd1,  S_FETCH3 = 4'd2,  S_DECODE = 4'd3,
        S_IMM    = 4'd4,  S_REG    = 4'd5,  S_LUI    = 4'd6,  S_AUIPC  = 4'd7,
        S_BR     = 4'd8,  S_JAL    = 4'd9,  S_JALR   = 4'd10, S_ADDR   = 4'd11,
        S_LD1    = 4'd12, S_LD2    = 4'd13, S_ST1    = 4'd14, S_HALT   = 4'd15
    } state_t;

    // RV32I major opcodes
    localparam logic [6:0] c_op_imm   = 7'b0010011;
    localparam logic [6:0] c_op_reg   = 7'b0110011;
    localparam logic [6:0] c_op_lui   = 7'b0110111;
    localparam logic [6:0] c_op_auipc = 7'b0010111;
    localparam logic [6:0] c_op_br    = 7'b1100011;
    localparam logic [6:0] c_op_jal   = 7'b1101111;
    localparam logic [6:0] c_op_jalr  = 7'b1100111;
    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;

    // ALU operations
    localparam logic [2:0] c_alu_add = 3'd0;
    localparam logic [2:0] c_alu_sra = 3'd2;
    localparam logic [2:0] c_alu_sub = 3'd3;

    // pcmux selects
    localparam logic [1:0] c_pc_plus4 = 2'd0;
    localparam logic [1:0] c_pc_alu   = 2'd1;
    localparam logic [1:0] c_pc_mod2  = 2'd2;

    // alumux2 selects
    localparam logic [2:0] c_a2_i   = 3'd0;
    localparam logic [2:0] c_a2_u   = 3'd1;
    localparam logic [2:0] c_a2_b   = 3'd2;
    localparam logic [2:0] c_a2_s   = 3'd3;
    localparam logic [2:0] c_a2_j   = 3'd4;
    localparam logic [2:0] c_a2_rs2 = 3'd5;

    // regfilemux selects
    localparam logic [3:0] c_rf_alu   = 4'd0;
    localparam logic [3:0] c_rf_br    = 4'd1;
    localparam logic [3:0] c_rf_u     = 4'd2;
    localparam logic [3:0] c_rf_lw    = 4'd3;
    localparam logic [3:0] c_rf_plus4 = 4'd4;
    localparam logic [3:0] c_rf_lb    = 4'd5;
    localparam logic [3:0] c_rf_lbu   = 4'd6;
    localparam logic [3:0] c_rf_lh    = 4'd7;
    localparam logic [3:0] c_rf_lhu   = 4'd8;

    // compare operations used by slt/sltu
    localparam logic [2:0] c_cmp_lt  = 3'b100;
    localparam logic [2:0] c_cmp_ltu = 3'b110;

    state_t r_state;
    state_t w_next_state;

    // Only funct7[5] distinguishes sub/sra; the other bits are don't-care.
    logic w_unused;
    assign w_unused = &{1'b0, funct7[6], funct7[4:0]};

    // State register; reset returns to FETCH1 from anywhere, even mid-request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH1;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and output decode; every output defaults first, reset forces defaults.
    always_comb begin
        w_next_state    = r_state;
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_data_out   = 1'b0;
        pcmux_sel       = c_pc_plus4;
        alumux1_sel     = 1'b0;
        alumux2_sel     = c_a2_i;
        regfilemux_sel  = c_rf_alu;
        marmux_sel      = 1'b0;
        cmpmux_sel      = 1'b0;
        cmpop           = 3'b000;
        aluop           = c_alu_add;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 4'b1111;
        illegal         = 1'b0;
        halted          = 1'b0;

        if (!rst) begin
            case (r_state)
                S_FETCH1: begin
                    load_mar     = 1'b1;
                    marmux_sel   = 1'b0;
                    w_next_state = S_FETCH2;
                end
                S_FETCH2: begin
                    mem_read = 1'b1;
                    load_mdr = 1'b1;
                    if (mem_resp) begin
                        w_next_state = S_FETCH3;
                    end
                end
                S_FETCH3: begin
                    load_ir      = 1'b1;
                    w_next_state = S_DECODE;
                end
                S_DECODE: begin
                    case (opcode)
                        c_op_imm:   w_next_state = S_IMM;
                        c_op_reg:   w_next_state = S_REG;
                        c_op_lui:   w_next_state = S_LUI;
                        c_op_auipc: w_next_state = S_AUIPC;
                        c_op_br:    w_next_state = S_BR;
                        c_op_jal:   w_next_state = S_JAL;
                        c_op_jalr:  w_next_state = S_JALR;
                        c_op_load,
                        c_op_store: w_next_state = S_ADDR;
                        default: begin
                            illegal = 1'b1;
                            if (ILLEGAL_SKIP) begin
                                load_pc      = 1'b1;
                                pcmux_sel    = c_pc_plus4;
                                w_next_state = S_FETCH1;
                            end else begin
                                w_next_state = S_HALT;
                            end
                        end
                    endcase
                end
                S_IMM: begin
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    alumux1_sel  = 1'b0;
                    alumux2_sel  = c_a2_i;
                    aluop        = funct3;
                    if (funct3 == 3'b010 || funct3 == 3'b011) begin
                        regfilemux_sel = c_rf_br;
                        cmpmux_sel     = 1'b1;
                        cmpop          = (funct3 == 3'b010) ? c_cmp_lt : c_cmp_ltu;
                    end
                    if (funct3 == 3'b101 && funct7[5]) begin
                        aluop = c_alu_sra;
                    end
                    w_next_state = S_FETCH1;
                end
                S_REG: begin
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    alumux1_sel  = 1'b0;
                    alumux2_sel  = c_a2_rs2;
                    aluop        = funct3;
                    if (funct3 == 3'b000 && funct7[5]) begin
                        aluop = c_alu_sub;
                    end
                    if (funct3 == 3'b101 && funct7[5]) begin
                        aluop = c_alu_sra;
                    end
                    if (funct3 == 3'b010 || funct3 == 3'b011) begin
                        regfilemux_sel = c_rf_br;
                        cmpmux_sel     = 1'b0;
                        cmpop          = (funct3 == 3'b010) ? c_cmp_lt : c_cmp_ltu;
                    end
                    w_next_state = S_FETCH1;
                end
                S_LUI: begin
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    regfilemux_sel = c_rf_u;
                    w_next_state   = S_FETCH1;
                end
                S_AUIPC: begin
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    alumux1_sel    = 1'b1;
                    alumux2_sel    = c_a2_u;
                    aluop          = c_alu_add;
                    regfilemux_sel = c_rf_alu;
                    w_next_state   = S_FETCH1;
                end
                S_BR: begin
                    load_pc      = 1'b1;
                    cmpop        = funct3;
                    cmpmux_sel   = 1'b0;
                    alumux1_sel  = 1'b1;
                    alumux2_sel  = c_a2_b;
                    aluop        = c_alu_add;
                    pcmux_sel    = br_en ? c_pc_alu : c_pc_plus4;
                    w_next_state = S_FETCH1;
                end
                S_JAL: begin
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    regfilemux_sel = c_rf_plus4;
                    alumux1_sel    = 1'b1;
                    alumux2_sel    = c_a2_j;
                    aluop          = c_alu_add;
                    pcmux_sel      = c_pc_alu;
                    w_next_state   = S_FETCH1;
                end
                S_JALR: begin
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    regfilemux_sel = c_rf_plus4;
                    alumux1_sel    = 1'b0;
                    alumux2_sel    = c_a2_i;
                    aluop          = c_alu_add;
                    pcmux_sel      = c_pc_mod2;
                    w_next_state   = S_FETCH1;
                end
                S_ADDR: begin
                    load_mar    = 1'b1;
                    marmux_sel  = 1'b1;
                    alumux1_sel = 1'b0;
                    aluop       = c_alu_add;
                    if (opcode == c_op_store) begin
                        alumux2_sel   = c_a2_s;
                        load_data_out = 1'b1;
                        w_next_state  = S_ST1;
                    end else begin
                        alumux2_sel  = c_a2_i;
                        w_next_state = S_LD1;
                    end
                end
                S_LD1: begin
                    mem_read = 1'b1;
                    load_mdr = 1'b1;
                    if (mem_resp) begin
                        w_next_state = S_LD2;
                    end
                end
                S_LD2: begin
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    case (funct3)
                        3'b000:  regfilemux_sel = c_rf_lb;
                        3'b001:  regfilemux_sel = c_rf_lh;
                        3'b100:  regfilemux_sel = c_rf_lbu;
                        3'b101:  regfilemux_sel = c_rf_lhu;
                        default: regfilemux_sel = c_rf_lw;
                    endcase
                    w_next_state = S_FETCH1;
                end
                S_ST1: begin
                    mem_write = 1'b1;
                    case (funct3)
                        3'b000:  mem_byte_enable = 4'b0001 << mar_lsb;
                        3'b001:  mem_byte_enable = 4'b0011 << mar_lsb;
                        default: mem_byte_enable = 4'b1111;
                    endcase
                    // PC update waits for the write to complete
                    if (mem_resp) begin
                        load_pc      = 1'b1;
                        w_next_state = S_FETCH1;
                    end
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    w_next_state = S_FETCH1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mp1_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mp1_control
//  Description : Self-checking bench for mp1_control. An instruction-level
//                reference model predicts latency, memory traffic and the
//                datapath controls at the retiring cycle of each instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mp1_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       br_en = 1'b0;
    logic [1:0] mar_lsb = '0;
    logic       mem_resp = 1'b0;

    logic load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
    logic [1:0] pcmux_sel;
    logic       alumux1_sel;
    logic [2:0] alumux2_sel;
    logic [3:0] regfilemux_sel;
    logic       marmux_sel, cmpmux_sel;
    logic [2:0] cmpop, aluop;
    logic       mem_read, mem_write;
    logic [3:0] mem_byte_enable;
    logic       illegal, halted;

    logic h_load_pc, h_load_ir, h_load_regfile, h_load_mar, h_load_mdr, h_load_data_out;
    logic [1:0] h_pcmux_sel;
    logic       h_alumux1_sel;
    logic [2:0] h_alumux2_sel;
    logic [3:0] h_regfilemux_sel;
    logic       h_marmux_sel, h_cmpmux_sel;
    logic [2:0] h_cmpop, h_aluop;
    logic       h_mem_read, h_mem_write;
    logic [3:0] h_mem_byte_enable;
    logic       h_illegal, h_halted;

    int n_assert  = 0;
    int n_fail    = 0;
    int h_ill_cnt = 0;

    always #5 clk = ~clk;

    mp1_control #(.ILLEGAL_SKIP(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .br_en(br_en), .mar_lsb(mar_lsb), .mem_resp(mem_resp),
        .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
        .load_mar(load_mar), .load_mdr(load_mdr), .load_data_out(load_data_out),
        .pcmux_sel(pcmux_sel), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
        .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel), .cmpmux_sel(cmpmux_sel),
        .cmpop(cmpop), .aluop(aluop), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .illegal(illegal), .halted(halted)
    );

    mp1_control #(.ILLEGAL_SKIP(1'b0)) dut_h (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .br_en(br_en), .mar_lsb(mar_lsb), .mem_resp(mem_resp),
        .load_pc(h_load_pc), .load_ir(h_load_ir), .load_regfile(h_load_regfile),
        .load_mar(h_load_mar), .load_mdr(h_load_mdr), .load_data_out(h_load_data_out),
        .pcmux_sel(h_pcmux_sel), .alumux1_sel(h_alumux1_sel), .alumux2_sel(h_alumux2_sel),
        .regfilemux_sel(h_regfilemux_sel), .marmux_sel(h_marmux_sel), .cmpmux_sel(h_cmpmux_sel),
        .cmpop(h_cmpop), .aluop(h_aluop), .mem_read(h_mem_read), .mem_write(h_mem_write),
        .mem_byte_enable(h_mem_byte_enable), .illegal(h_illegal), .halted(h_halted)
    );

    // Instruction-level expectation
    typedef struct {
        int cycles;
        int rd_cycles;
        int wr_cycles;
        int is_illegal;
        int is_load;
        int is_store;
        int ld_reg;
        int rfmux;
        int pcmux;
        int alu_care;
        int aluop;
        int am1;
        int am2;
        int cmp_care;
        int cmpmux;
        int cmpop;
        int be;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic string base_mnemonic(input logic [2:0] f3);
        case (f3)
            3'd0:    return "add";
            3'd1:    return "sll";
            3'd2:    return "slt";
            3'd3:    return "sltu";
            3'd4:    return "xor";
            3'd5:    return "srl";
            3'd6:    return "or";
            default: return "and";
        endcase
    endfunction

    function automatic int alu_code(input string mn);
        if (mn == "add") return 0;
        if (mn == "sll") return 1;
        if (mn == "sra") return 2;
        if (mn == "sub") return 3;
        if (mn == "xor") return 4;
        if (mn == "srl") return 5;
        if (mn == "or")  return 6;
        return 7;
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0000011, 7'b0100011};
    endfunction

    // Reference model: FETCH1 + fetch wait + FETCH3 + DECODE, then the execute path
    function automatic exp_t predict(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic br,
                                     input logic [1:0] lsb, input int flat, input int mlat);
        exp_t  e;
        string mn;
        bit    reg_form;
        int    lanes;
        e = '{default: 0};
        e.cycles    = 3 + flat;
        e.rd_cycles = flat;
        reg_form    = (op == 7'b0110011);
        case (op)
            7'b0010011, 7'b0110011: begin
                mn = base_mnemonic(f3);
                if (f3 == 3'd5 && f7[5]) mn = "sra";
                if (reg_form && f3 == 3'd0 && f7[5]) mn = "sub";
                e.cycles += 1;
                e.ld_reg = 1;
                e.am2    = reg_form ? 5 : 0;
                if (mn == "slt" || mn == "sltu") begin
                    e.rfmux    = 1;
                    e.cmp_care = 1;
                    e.cmpmux   = reg_form ? 0 : 1;
                    e.cmpop    = (mn == "slt") ? 4 : 6;
                end else begin
                    e.alu_care = 1;
                    e.aluop    = alu_code(mn);
                end
            end
            7'b0110111: begin
                e.cycles += 1; e.ld_reg = 1; e.rfmux = 2;
            end
            7'b0010111: begin
                e.cycles += 1; e.ld_reg = 1; e.rfmux = 0;
                e.alu_care = 1; e.am1 = 1; e.am2 = 1; e.aluop = 0;
            end
            7'b1100011: begin
                e.cycles += 1; e.pcmux = br ? 1 : 0;
                e.alu_care = 1; e.am1 = 1; e.am2 = 2; e.aluop = 0;
                e.cmp_care = 1; e.cmpmux = 0; e.cmpop = int'(f3);
            end
            7'b1101111: begin
                e.cycles += 1; e.ld_reg = 1; e.rfmux = 4; e.pcmux = 1;
                e.alu_care = 1; e.am1 = 1; e.am2 = 4; e.aluop = 0;
            end
            7'b1100111: begin
                e.cycles += 1; e.ld_reg = 1; e.rfmux = 4; e.pcmux = 2;
                e.alu_care = 1; e.am1 = 0; e.am2 = 0; e.aluop = 0;
            end
            7'b0000011: begin
                e.is_load = 1;
                e.cycles += 2 + mlat;
                e.rd_cycles += mlat;
                e.ld_reg = 1;
                case (f3)
                    3'd0:    e.rfmux = 5;
                    3'd1:    e.rfmux = 7;
                    3'd4:    e.rfmux = 6;
                    3'd5:    e.rfmux = 8;
                    default: e.rfmux = 3;
                endcase
            end
            7'b0100011: begin
                e.is_store  = 1;
                e.cycles   += 1 + mlat;
                e.wr_cycles = mlat;
                lanes = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
                e.be  = (lanes == 4) ? 15 : ((((1 << lanes) - 1) << lsb) & 15);
            end
            default: e.is_illegal = 1;
        endcase
        return e;
    endfunction

    // Runs one instruction starting in FETCH1 (called just after a falling edge)
    task automatic run_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic br, input logic [1:0] lsb,
                             input int flat, input int mlat);
        exp_t e;
        int cyc = 0, req = 0, rd = 0, wr = 0, nmar = 0, nir = 0, nill = 0;
        bit ir_seen = 0, done = 0;
        e = predict(op, f3, f7, br, lsb, flat, mlat);
        opcode = op; funct3 = f3; funct7 = f7; br_en = br; mar_lsb = lsb;
        mem_resp = 1'b0;
        while (!done && cyc < 60) begin
            cyc++;
            #1;
            if (mem_read || mem_write) begin
                req++;
                if (req == (ir_seen ? mlat : flat)) begin
                    mem_resp = 1'b1;
                    req = 0;
                    #1;
                end
            end
            chk({nm, ":rd_wr_excl"}, 32'(mem_read & mem_write), 32'd0);
            chk({nm, ":halted"}, 32'(halted), 32'd0);
            if ((mem_read || mem_write) && !mem_resp)
                chk({nm, ":load_during_req"},
                    32'({load_pc, load_ir, load_regfile, load_mar, load_data_out}), 32'd0);
            rd   += int'(mem_read);
            wr   += int'(mem_write);
            nmar += int'(load_mar);
            nir  += int'(load_ir);
            nill += int'(illegal);
            h_ill_cnt += int'(h_illegal);
            if (load_mar && !ir_seen)
                chk({nm, ":fetch_marmux"}, 32'(marmux_sel), 32'd0);
            if (load_mar && ir_seen) begin
                chk({nm, ":addr_marmux"}, 32'(marmux_sel), 32'd1);
                chk({nm, ":addr_alu"}, 32'({alumux1_sel, aluop}), 32'd0);
                chk({nm, ":addr_am2"}, 32'(alumux2_sel), e.is_store ? 32'd3 : 32'd0);
                chk({nm, ":addr_ldo"}, 32'(load_data_out), 32'(e.is_store));
            end
            if (load_ir) ir_seen = 1;
            if (mem_write)
                chk({nm, ":byte_en"}, 32'(mem_byte_enable), 32'(e.be));
            if (load_pc) begin
                done = 1;
                chk({nm, ":pcmux"}, 32'(pcmux_sel), 32'(e.pcmux));
                chk({nm, ":ld_reg"}, 32'(load_regfile), 32'(e.ld_reg));
                if (e.ld_reg != 0)
                    chk({nm, ":rfmux"}, 32'(regfilemux_sel), 32'(e.rfmux));
                if (e.alu_care != 0) begin
                    chk({nm, ":aluop"}, 32'(aluop), 32'(e.aluop));
                    chk({nm, ":alumux1"}, 32'(alumux1_sel), 32'(e.am1));
                    chk({nm, ":alumux2"}, 32'(alumux2_sel), 32'(e.am2));
                end
                if (e.cmp_care != 0) begin
                    chk({nm, ":cmpmux"}, 32'(cmpmux_sel), 32'(e.cmpmux));
                    chk({nm, ":cmpop"}, 32'(cmpop), 32'(e.cmpop));
                end
            end
            @(negedge clk);
            mem_resp = 1'b0;
        end
        if (!done) chk({nm, ":timeout"}, 32'd0, 32'd1);
        chk({nm, ":cycles"}, 32'(cyc), 32'(e.cycles));
        chk({nm, ":load_ir_cnt"}, 32'(nir), 32'd1);
        chk({nm, ":load_mar_cnt"}, 32'(nmar), (e.is_load | e.is_store) != 0 ? 32'd2 : 32'd1);
        chk({nm, ":read_cycles"}, 32'(rd), 32'(e.rd_cycles));
        chk({nm, ":write_cycles"}, 32'(wr), 32'(e.wr_cycles));
        chk({nm, ":illegal_cnt"}, 32'(nill), 32'(e.is_illegal));
    endtask

    // Holds reset for one cycle, checks default outputs, releases reset
    task automatic do_reset();
        rst = 1'b1;
        mem_resp = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_loads", 32'({load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out}), 32'd0);
        chk("rst_sels", 32'({pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel,
                             marmux_sel, cmpmux_sel, cmpop, aluop}), 32'd0);
        chk("rst_mem", 32'({mem_read, mem_write, illegal, halted}), 32'd0);
        chk("rst_byte_en", 32'(mem_byte_enable), 32'hF);
        chk("rst_h_halted", 32'(h_halted), 32'd0);
        rst = 1'b0;
    endtask

    logic [6:0] legal_ops [9];

    initial begin
        logic [6:0] op;
        logic [6:0] f7;
        legal_ops = '{7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0000011, 7'b0100011};

        @(negedge clk);
        do_reset();

        // reset while FETCH2 has a request outstanding; a concurrent mem_resp is ignored
        opcode = 7'b0010011; funct3 = 3'd0; funct7 = 7'd0;
        #1 chk("rstf2_fetch1", 32'(load_mar), 32'd1);
        @(negedge clk);
        #1 chk("rstf2_read_before", 32'(mem_read), 32'd1);
        rst = 1'b1;
        mem_resp = 1'b1;
        #1;
        chk("rstf2_read_during", 32'(mem_read), 32'd0);
        chk("rstf2_mdr_during", 32'(load_mdr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_resp = 1'b0;
        #1;
        chk("rstf2_back_fetch1", 32'(load_mar), 32'd1);
        chk("rstf2_no_read", 32'(mem_read), 32'd0);

        // directed instructions
        run_instr("addi",  7'b0010011, 3'd0, 7'h00, 1'b0, 2'd0, 3, 1);
        run_instr("srai",  7'b0010011, 3'd5, 7'h20, 1'b0, 2'd0, 1, 1);
        run_instr("srli",  7'b0010011, 3'd5, 7'h00, 1'b0, 2'd0, 2, 1);
        run_instr("slti",  7'b0010011, 3'd2, 7'h00, 1'b0, 2'd0, 1, 1);
        run_instr("sltiu", 7'b0010011, 3'd3, 7'h00, 1'b0, 2'd0, 1, 1);
        run_instr("sub",   7'b0110011, 3'd0, 7'h20, 1'b0, 2'd0, 1, 1);
        run_instr("add",   7'b0110011, 3'd0, 7'h00, 1'b0, 2'd0, 1, 1);
        run_instr("sra",   7'b0110011, 3'd5, 7'h20, 1'b0, 2'd0, 1, 1);
        run_instr("sltu",  7'b0110011, 3'd3, 7'h00, 1'b0, 2'd0, 1, 1);
        run_instr("beq_t", 7'b1100011, 3'd0, 7'h00, 1'b1, 2'd0, 1, 1);
        run_instr("beq_n", 7'b1100011, 3'd0, 7'h00, 1'b0, 2'd0, 1, 1);
        run_instr("sb",    7'b0100011, 3'd0, 7'h00, 1'b0, 2'd2, 1, 3);
        run_instr("sh",    7'b0100011, 3'd1, 7'h00, 1'b0, 2'd2, 2, 2);
        run_instr("sh3",   7'b0100011, 3'd1, 7'h00, 1'b0, 2'd3, 1, 1);
        run_instr("sw",    7'b0100011, 3'd2, 7'h00, 1'b0, 2'd0, 1, 1);
        run_instr("lhu",   7'b0000011, 3'd5, 7'h00, 1'b0, 2'd0, 1, 2);
        run_instr("lb",    7'b0000011, 3'd0, 7'h00, 1'b0, 2'd1, 2, 1);
        run_instr("lui",   7'b0110111, 3'd0, 7'h00, 1'b0, 2'd0, 1, 1);
        run_instr("auipc", 7'b0010111, 3'd0, 7'h00, 1'b0, 2'd0, 1, 1);
        run_instr("jal",   7'b1101111, 3'd0, 7'h00, 1'b0, 2'd0, 1, 1);
        run_instr("jalr",  7'b1100111, 3'd0, 7'h00, 1'b0, 2'd0, 1, 1);

        // unknown opcode: skip variant advances, halt variant parks in HALT
        h_ill_cnt = 0;
        run_instr("illegal0", 7'b0000000, 3'd0, 7'h00, 1'b0, 2'd0, 1, 1);
        chk("halt_ill_pulse", 32'(h_ill_cnt), 32'd1);
        chk("halt_entered", 32'(h_halted), 32'd1);
        run_instr("after_illegal", 7'b0010011, 3'd0, 7'h00, 1'b0, 2'd0, 1, 1);
        chk("halt_stays", 32'(h_halted), 32'd1);
        chk("halt_quiet", 32'({h_mem_read, h_mem_write, h_load_pc, h_load_mar}), 32'd0);
        chk("halt_ill_once", 32'(h_ill_cnt), 32'd1);
        do_reset();
        #1 chk("halt_cleared", 32'(h_halted), 32'd0);

        // randomized instruction stream
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                do op = 7'($urandom_range(0, 127)); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 8)];
            end
            case ($urandom_range(0, 2))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                default: f7 = 7'($urandom_range(0, 127));
            endcase
            run_instr($sformatf("rnd%0d", i), op, 3'($urandom_range(0, 7)), f7,
                      1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
